fifo_async_read_ctrl: RTL and testbench

- Read-domain controller of the asynchronous circular FIFO.
- Sits directly downstream of the write-pointer stage. It receives that stage's Gray write pointer across the clock boundary and synchronises it. It drives the RAM read port and returns its own Gray read pointer to the write side.
- It presents data to the consumer as first-word-fall-through through a 2-entry output buffer with valid/ready handshake, so back-to-back pops run at full rate.

---
 rtl/fifo_async_read_ctrl_if.sv | 33 +++
 rtl/fifo_async_read_ctrl.sv | 124 ++++++++++++
 tb/tb_fifo_async_read_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_async_read_ctrl_if.sv
// rtl/fifo_async_read_ctrl_if.sv - read-side RAM port and consumer stream bundle
//
// Purpose: groups the RAM read port and the first-word-fall-through consumer
// handshake of the async FIFO read controller.
// Signals:
//   mem_raddr_out  RAM read address (DEPTH entries)
//   mem_ren_out    RAM read enable
//   mem_rdata_in   RAM read data, one cycle after mem_ren_out
//   dout_out       head word
//   dout_valid_out head word valid
//   dout_ready_in  consumer accepts head
// Modports: master = read controller, slave = RAM + consumer side.
interface fifo_async_read_ctrl_if #(
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = 4
);
  logic [PTR_WIDTH-2:0] mem_raddr_out;
  logic                 mem_ren_out;
  logic [WIDTH-1:0]     mem_rdata_in;
  logic [WIDTH-1:0]     dout_out;
  logic                 dout_valid_out;
  logic                 dout_ready_in;

  modport master (
    output mem_raddr_out, mem_ren_out, dout_out, dout_valid_out,
    input  mem_rdata_in, dout_ready_in
  );

  modport slave (
    input  mem_raddr_out, mem_ren_out, dout_out, dout_valid_out,
    output mem_rdata_in, dout_ready_in
  );
endinterface

// File: rtl/fifo_async_read_ctrl.sv
// rtl/fifo_async_read_ctrl.sv - read-domain controller of the async circular FIFO
//
// Purpose: synchronises the Gray write pointer, issues RAM reads and presents
// the data first-word-fall-through through a 2-entry head/skid buffer.
// Ports:
//   clk_in           read-domain clock (posedge)
//   rst_in           synchronous active-high reset
//   wptr_g_in        Gray write pointer from the write domain (asynchronous)
//   rptr_g_out       registered Gray read pointer to the write domain
//   level_out        words not yet popped (RAM + in-flight + buffer)
//   almost_empty_out level_out <= AE_LEVEL
//   bus              RAM read port and consumer stream (master modport)
module fifo_async_read_ctrl #(
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = 4,
  parameter int AE_LEVEL  = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [PTR_WIDTH-1:0] wptr_g_in,
  output logic [PTR_WIDTH-1:0] rptr_g_out,
  output logic [PTR_WIDTH-1:0] level_out,
  output logic                 almost_empty_out,
  fifo_async_read_ctrl_if.master bus
);

  localparam logic [PTR_WIDTH-1:0] AE_THRESH = PTR_WIDTH'(AE_LEVEL);

  // Buffer state is encoded as {buf_cnt, pending} so the counts fall out
  // of the state bits directly.
  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    FETCH     = 3'b001,
    ONE       = 3'b010,
    ONE_FETCH = 3'b011,
    FULL      = 3'b100
  } buf_state_t;

  function automatic logic [PTR_WIDTH-1:0] bin2gray(input logic [PTR_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
    logic [PTR_WIDTH-1:0] b;
    b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
    for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PTR_WIDTH-1:0] wsync1;
  logic [PTR_WIDTH-1:0] wsync2;
  logic [PTR_WIDTH-1:0] rptr_b;
  logic [WIDTH-1:0]     head;
  logic [WIDTH-1:0]     skid;
  buf_state_t           buf_state;

  logic [PTR_WIDTH-1:0] wptr_b_sync;
  logic [PTR_WIDTH-1:0] rptr_b_next;
  logic [1:0]           buf_cnt;
  logic                 pending;
  logic                 mem_empty;
  logic                 pop;
  logic                 ren;
  logic [1:0]           occ_after_pop;

  assign buf_cnt     = buf_state[2:1];
  assign pending     = buf_state[0];
  assign wptr_b_sync = gray2bin(wsync2);
  assign mem_empty   = (rptr_b == wptr_b_sync);
  assign pop         = (buf_cnt != 2'd0) && bus.dout_ready_in;

  // Slots still claimed after this cycle's pop; a new read may only be
  // issued if it will have somewhere to land.
  assign occ_after_pop = buf_cnt + {1'b0, pending} - {1'b0, pop};
  assign ren           = !mem_empty && (occ_after_pop != 2'd2);
  assign rptr_b_next   = rptr_b + {{(PTR_WIDTH-1){1'b0}}, ren};

  assign bus.mem_ren_out    = ren;
  assign bus.mem_raddr_out  = rptr_b[PTR_WIDTH-2:0];
  assign bus.dout_out       = head;
  assign bus.dout_valid_out = (buf_cnt != 2'd0);

  // Unread RAM words plus the read in flight plus buffered words.
  assign level_out = (wptr_b_sync - rptr_b)
                   + {{(PTR_WIDTH-1){1'b0}}, pending}
                   + {{(PTR_WIDTH-2){1'b0}}, buf_cnt};
  assign almost_empty_out = (level_out <= AE_THRESH);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wsync1     <= '0;
      wsync2     <= '0;
      rptr_b     <= '0;
      rptr_g_out <= '0;
      head       <= '0;
      skid       <= '0;
      buf_state  <= IDLE;
    end else begin
      wsync1     <= wptr_g_in;
      wsync2     <= wsync1;
      rptr_b     <= rptr_b_next;
      rptr_g_out <= bin2gray(rptr_b_next);
      buf_state  <= buf_state_t'({occ_after_pop, ren});

      if (pop && buf_cnt == 2'd2) begin
        // Skid advances; any arriving word refills the skid behind it.
        head <= skid;
        if (pending) begin
          skid <= bus.mem_rdata_in;
        end
      end else if (pending) begin
        // Head is free (empty, or its single word leaves this cycle).
        if (buf_cnt == 2'd0 || pop) begin
          head <= bus.mem_rdata_in;
        end else begin
          skid <= bus.mem_rdata_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_async_read_ctrl.sv
// tb/tb_fifo_async_read_ctrl.sv - bench for fifo_async_read_ctrl
module tb_fifo_async_read_ctrl;
  localparam int WIDTH     = 8;
  localparam int PTR_WIDTH = 4;
  localparam int DEPTH     = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] wptr_g;
  logic [3:0] rptr_g;
  logic [3:0] level;
  logic       ae;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fifo_async_read_ctrl_if #(.WIDTH(WIDTH), .PTR_WIDTH(PTR_WIDTH)) bus ();

  fifo_async_read_ctrl #(.WIDTH(WIDTH), .PTR_WIDTH(PTR_WIDTH), .AE_LEVEL(1)) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .wptr_g_in        (wptr_g),
    .rptr_g_out       (rptr_g),
    .level_out        (level),
    .almost_empty_out (ae),
    .bus              (bus.master)
  );

  // Synchronous-read RAM shared with the write side (the bench).
  logic [7:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_ren_out) bus.mem_rdata_in <= ram[bus.mem_raddr_out];
  end

  function automatic logic [3:0] gray(input int b);
    logic [3:0] x;
    x = b[3:0];
    return x ^ (x >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next(input logic r, input logic [3:0] wg, input logic rdy);
    @(negedge clk);
    rst = r;
    wptr_g = wg;
    bus.dout_ready_in = rdy;
    #1;
  endtask

  task automatic do_reset();
    next(1'b1, 4'd0, 1'b0);
    next(1'b1, 4'd0, 1'b0);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] wg;
    logic       rdy;
    logic       chk;
    logic       valid;
    logic       ren;
    logic [2:0] raddr;
    logic [3:0] rg;
    logic [3:0] lvl;
    logic       ae;
    logic       cd;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[10];

  // Random-phase model state
  logic [7:0] q[$];
  int wb, popped, reads, h1, h2;

  task automatic rand_cycle(input bit allow_write, input bit rdy);
    int exp_lvl;
    logic [7:0] d;
    @(negedge clk);
    rst = 1'b0;
    if (allow_write && $urandom_range(0, 1) == 1 && (wb - popped) < DEPTH) begin
      d = 8'($urandom);
      ram[wb % DEPTH] = d;
      q.push_back(d);
      wb++;
    end
    wptr_g = gray(wb);
    bus.dout_ready_in = rdy;
    #1;
    exp_lvl = h2 - popped;
    check("rnd_level", int'(level), exp_lvl);
    check("rnd_ae", int'(ae), int'(exp_lvl <= 1));
    if (bus.mem_ren_out) begin
      check("rnd_raddr", int'(bus.mem_raddr_out), reads % DEPTH);
      reads++;
    end
    if (bus.dout_valid_out) begin
      check("rnd_nonempty", int'(q.size() != 0), 1);
      if (q.size() != 0) begin
        check("rnd_dout", int'(bus.dout_out), int'(q[0]));
        if (rdy) begin
          void'(q.pop_front());
          popped++;
        end
      end
    end
    h2 = h1;
    h1 = wb;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    int first, last;
    int got[$];
    int addrs[$];
    int stale;

    rst = 1'b1;
    wptr_g = '0;
    bus.dout_ready_in = 1'b0;
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'h00;

    // Directed single-word vectors: reset, then wptr 0 -> 1 with RAM[0]=0xA5.
    ram[0] = 8'hA5;
    tbl[0] = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 1'b1, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 1'b1, 1'b1, 8'h00};
    tbl[2] = '{1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 1'b1, 1'b0, 8'h00};
    tbl[3] = '{1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 1'b1, 1'b0, 8'h00};
    tbl[4] = '{1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 4'd0, 4'd1, 1'b1, 1'b0, 8'h00};
    tbl[5] = '{1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 4'd1, 4'd1, 1'b1, 1'b0, 8'h00};
    tbl[6] = '{1'b0, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 4'd1, 4'd1, 1'b1, 1'b1, 8'hA5};
    tbl[7] = '{1'b0, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 4'd1, 4'd1, 1'b1, 1'b1, 8'hA5};
    tbl[8] = '{1'b0, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 4'd1, 4'd1, 1'b1, 1'b1, 8'hA5};
    tbl[9] = '{1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 4'd1, 4'd0, 1'b1, 1'b0, 8'h00};

    for (int i = 0; i < 10; i++) begin
      next(tbl[i].rst, tbl[i].wg, tbl[i].rdy);
      if (tbl[i].chk) begin
        check($sformatf("t%0d_valid", i), int'(bus.dout_valid_out), int'(tbl[i].valid));
        check($sformatf("t%0d_ren", i), int'(bus.mem_ren_out), int'(tbl[i].ren));
        check($sformatf("t%0d_raddr", i), int'(bus.mem_raddr_out), int'(tbl[i].raddr));
        check($sformatf("t%0d_rptr_g", i), int'(rptr_g), int'(tbl[i].rg));
        check($sformatf("t%0d_level", i), int'(level), int'(tbl[i].lvl));
        check($sformatf("t%0d_ae", i), int'(ae), int'(tbl[i].ae));
        if (tbl[i].cd) check($sformatf("t%0d_dout", i), int'(bus.dout_out), int'(tbl[i].dout));
      end
    end

    // Stream: 8 words at full rate.
    do_reset();
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'h10 + 8'(i);
    first = -1;
    last = -1;
    got.delete();
    for (int c = 0; c < 30; c++) begin
      next(1'b0, 4'b1100, 1'b1);
      if (bus.dout_valid_out) begin
        got.push_back(int'(bus.dout_out));
        if (first < 0) first = c;
        last = c;
      end
    end
    check("stream_count", got.size(), 8);
    for (int i = 0; i < 8; i++) check("stream_word", (i < got.size()) ? got[i] : -1, 'h10 + i);
    check("stream_contig", last - first, 7);
    check("stream_level", int'(level), 0);
    check("stream_rptr_g", int'(rptr_g), 'b1100);

    // Backpressure: only two reads outstanding, head stable.
    do_reset();
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      next(1'b0, 4'b1100, 1'b0);
      if (bus.mem_ren_out) cnt++;
    end
    check("bp_reads", cnt, 2);
    check("bp_level", int'(level), 8);
    check("bp_valid", int'(bus.dout_valid_out), 1);
    check("bp_dout", int'(bus.dout_out), 'h10);
    next(1'b0, 4'b1100, 1'b1);
    check("bp_pop_dout", int'(bus.dout_out), 'h10);
    if (bus.mem_ren_out) cnt++;
    next(1'b0, 4'b1100, 1'b0);
    check("bp_next_dout", int'(bus.dout_out), 'h11);
    if (bus.mem_ren_out) cnt++;
    for (int c = 0; c < 4; c++) begin
      next(1'b0, 4'b1100, 1'b0);
      if (bus.mem_ren_out) cnt++;
    end
    check("bp_reads_after", cnt, 3);
    check("bp_level_after", int'(level), 7);

    // Wrap: consume 6, then advance to 10 so the address wraps 7 -> 0.
    do_reset();
    for (int c = 0; c < 20; c++) next(1'b0, gray(6), 1'b1);
    check("wrap_pre_level", int'(level), 0);
    check("wrap_pre_rptr_g", int'(rptr_g), int'(gray(6)));
    ram[6] = 8'hA6;
    ram[7] = 8'hA7;
    ram[0] = 8'hA8;
    ram[1] = 8'hA9;
    addrs.delete();
    got.delete();
    for (int c = 0; c < 20; c++) begin
      next(1'b0, 4'b1111, 1'b1);
      if (bus.mem_ren_out) addrs.push_back(int'(bus.mem_raddr_out));
      if (bus.dout_valid_out) got.push_back(int'(bus.dout_out));
    end
    check("wrap_nreads", addrs.size(), 4);
    check("wrap_nwords", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("wrap_addr", (i < addrs.size()) ? addrs[i] : -1, (6 + i) % DEPTH);
      check("wrap_word", (i < got.size()) ? got[i] : -1, 'hA6 + i);
    end
    check("wrap_rptr_g", int'(rptr_g), 'b1111);
    check("wrap_level", int'(level), 0);

    // Mid-operation reset with a read in flight behind a valid head.
    do_reset();
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'h10 + 8'(i);
    cnt = 0;
    while (cnt < 20 && !bus.dout_valid_out) begin
      next(1'b0, 4'b1100, 1'b0);
      cnt++;
    end
    check("midrst_reach_valid", int'(bus.dout_valid_out), 1);
    next(1'b1, 4'd0, 1'b0);
    next(1'b0, 4'd0, 1'b0);
    check("midrst_valid", int'(bus.dout_valid_out), 0);
    check("midrst_level", int'(level), 0);
    check("midrst_ren", int'(bus.mem_ren_out), 0);
    check("midrst_ae", int'(ae), 1);
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      next(1'b0, 4'd0, 1'b1);
      if (bus.dout_valid_out) stale++;
    end
    check("midrst_no_stale", stale, 0);

    // Randomized traffic against the queue model.
    do_reset();
    q.delete();
    wb = 0;
    popped = 0;
    reads = 0;
    h1 = 0;
    h2 = 0;
    for (int it = 0; it < 900; it++) begin
      if (it < 300) rand_cycle(1'b1, $urandom_range(0, 3) != 0);
      else if (it < 600) rand_cycle(1'b1, $urandom_range(0, 3) == 0);
      else rand_cycle(1'b1, 1'b1);
    end
    for (int it = 0; it < 40; it++) rand_cycle(1'b0, 1'b1);
    check("rnd_drained", q.size(), 0);
    check("rnd_final_level", int'(level), 0);
    check("rnd_final_rptr_g", int'(rptr_g), int'(gray(wb)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
